// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the conv window scheduler
package conv_pkg;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam logic [15:0] FP16_ONE = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_CONV, S_WRITE, S_GAP, S_DONE} state_t;
endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: kernel-element and output-window counters producing image/result addresses
module conv_addr_gen #(
  parameter int IN_CH = 1,
  parameter int K_LEN = 3,
  parameter int K_WID = 3,
  parameter int IMG_H = 28,
  parameter int IMG_W = 28,
  parameter int STRIDE = 1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  rd_step,
  input  logic                  win_step,
  output logic [ADDR_WIDTH-1:0] img_rd_addr,
  output logic [ADDR_WIDTH-1:0] res_wr_addr,
  output logic                  rd_last,
  output logic                  win_last
);
  localparam int OUT_H = (IMG_H - K_LEN) / STRIDE + 1;
  localparam int OUT_W = (IMG_W - K_WID) / STRIDE + 1;
  localparam int CW = $clog2(IN_CH) + 1;
  localparam int RW = $clog2(K_LEN) + 1;
  localparam int KW = $clog2(K_WID) + 1;
  localparam int OHW = $clog2(OUT_H) + 1;
  localparam int OWW = $clog2(OUT_W) + 1;
  localparam logic [CW-1:0] C_MAX = CW'(IN_CH - 1);
  localparam logic [RW-1:0] KR_MAX = RW'(K_LEN - 1);
  localparam logic [KW-1:0] KC_MAX = KW'(K_WID - 1);
  localparam logic [OHW-1:0] OR_MAX = OHW'(OUT_H - 1);
  localparam logic [OWW-1:0] OC_MAX = OWW'(OUT_W - 1);
  logic [CW-1:0] c;
  logic [RW-1:0] kr;
  logic [KW-1:0] kc;
  logic [OHW-1:0] orow;
  logic [OWW-1:0] ocol;
  logic kc_wrap, kr_wrap, ocol_wrap;
  assign kc_wrap = kc == KC_MAX;
  assign kr_wrap = kr == KR_MAX;
  assign ocol_wrap = ocol == OC_MAX;
  assign rd_last = (c == C_MAX) && kr_wrap && kc_wrap;
  assign win_last = (orow == OR_MAX) && ocol_wrap;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c <= '0;
      kr <= '0;
      kc <= '0;
      orow <= '0;
      ocol <= '0;
    end else if (clear) begin
      c <= '0;
      kr <= '0;
      kc <= '0;
      orow <= '0;
      ocol <= '0;
    end else begin
      if (rd_step) begin
        kc <= kc_wrap ? '0 : kc + KW'(1);
        if (kc_wrap) kr <= kr_wrap ? '0 : kr + RW'(1);
        if (kc_wrap && kr_wrap) c <= (c == C_MAX) ? '0 : c + CW'(1);
      end
      if (win_step) begin
        ocol <= ocol_wrap ? '0 : ocol + OWW'(1);
        if (ocol_wrap) orow <= (orow == OR_MAX) ? '0 : orow + OHW'(1);
      end
    end
  end
  assign img_rd_addr = ADDR_WIDTH'(c) * ADDR_WIDTH'(IMG_H * IMG_W)
                     + (ADDR_WIDTH'(orow) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(kr)) * ADDR_WIDTH'(IMG_W)
                     + ADDR_WIDTH'(ocol) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(kc);
  assign res_wr_addr = ADDR_WIDTH'(orow) * ADDR_WIDTH'(OUT_W) + ADDR_WIDTH'(ocol);
endmodule

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks a convUnit over a feature map, fetching each window,
// running the unit to completion and storing its result in row-major output order.
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IN_CH = 1,
  parameter int K_LEN = 3,
  parameter int K_WID = 3,
  parameter int IMG_H = 28,
  parameter int IMG_W = 28,
  parameter int STRIDE = 1,
  parameter int ADDR_WIDTH = 16,
  localparam int N = IN_CH * K_LEN * K_WID
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    img_rd_en,
  output logic [ADDR_WIDTH-1:0]   img_rd_addr,
  input  logic [DATA_WIDTH-1:0]   img_rd_data,
  output logic [0:N*DATA_WIDTH-1] patch,
  output logic                    cu_conv_en,
  input  logic                    cu_out_valid,
  input  logic [DATA_WIDTH-1:0]   cu_result,
  output logic                    res_wr_en,
  output logic [ADDR_WIDTH-1:0]   res_wr_addr,
  output logic [DATA_WIDTH-1:0]   res_wr_data
);
  localparam int IW = $clog2(N) + 1;
  state_t state, nxt;
  logic rd_last, win_last;
  logic [IW-1:0] idx, cap_idx;
  logic cap_vld;
  logic [DATA_WIDTH-1:0] res_q;
  conv_addr_gen #(
    .IN_CH(IN_CH), .K_LEN(K_LEN), .K_WID(K_WID), .IMG_H(IMG_H), .IMG_W(IMG_W),
    .STRIDE(STRIDE), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr (
    .clk(clk),
    .reset(reset),
    .clear(state == S_DONE),
    .rd_step(state == S_FETCH),
    .win_step(state == S_GAP && !win_last),
    .img_rd_addr(img_rd_addr),
    .res_wr_addr(res_wr_addr),
    .rd_last(rd_last),
    .win_last(win_last)
  );
  always_comb begin
    nxt = state;
    busy = 1'b1;
    done = 1'b0;
    img_rd_en = 1'b0;
    cu_conv_en = 1'b0;
    res_wr_en = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        nxt = start ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        img_rd_en = 1'b1;
        nxt = rd_last ? S_DRAIN : S_FETCH;
      end
      S_DRAIN: nxt = S_CONV;
      S_CONV: begin
        cu_conv_en = 1'b1;
        nxt = cu_out_valid ? S_WRITE : S_CONV;
      end
      S_WRITE: begin
        res_wr_en = 1'b1;
        nxt = S_GAP;
      end
      S_GAP: nxt = win_last ? S_DONE : S_FETCH;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        nxt = S_IDLE;
      end
      default: begin
        busy = 1'b0;
        nxt = S_IDLE;
      end
    endcase
  end
  // read data lands one cycle after its strobe, so the slot index is delayed with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx <= '0;
      cap_idx <= '0;
      cap_vld <= 1'b0;
      patch <= '0;
      res_q <= '0;
    end else begin
      state <= nxt;
      idx <= (img_rd_en && !rd_last) ? idx + IW'(1) : '0;
      cap_idx <= idx;
      cap_vld <= img_rd_en;
      if (cap_vld) patch[int'(cap_idx)*DATA_WIDTH +: DATA_WIDTH] <= img_rd_data;
      if (state == S_CONV && cu_out_valid) res_q <= cu_result;
    end
  end
  assign res_wr_data = res_q;
endmodule
